multicycle_ctrl: RTL and testbench

Multi-cycle control FSM that sequences a single shared ALU and a single unified instruction/data memory port for the MIPS-subset CPU. The instruction set is R-type (add, sub, and, or, slt, sllv, sll, srlv, srl, mul, jr), addi, ori, lui, lw, sw, beq, bgt, bnez, bgez, j and jal. It decodes opcode/funct from the instruction register and drives every datapath mux select and write strobe, one state per cycle. Memory accesses use a req/ack handshake.

---
 rtl/multicycle_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM sequencing the shared ALU and unified memory port
// Optional feature macro: MUL_STALL_EN (mul holds EXEC for MUL_CYCLES cycles before WB)
module multicycle_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       neg_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] wb_sel_o,
  output logic       alu_a_sel_o,
  output logic [1:0] alu_b_sel_o,
  output logic       zext_o,
  output logic [1:0] alu_op_o,
  output logic [2:0] state_o,
  output logic       err_o
);

  // Opcode encodings (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BGEZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct encodings (IR[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MUL  = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2a;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_MUL, C_JR, C_J, C_JAL,
    C_BEQ, C_BNEZ, C_BGEZ, C_BGT,
    C_LW, C_SW, C_ADDI, C_ORI, C_LUI,
    C_ILL
  } iclass_t;

  // Map opcode/funct onto an instruction class; anything unlisted is illegal
  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
    iclass_t c;
    c = C_ILL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT,
          F_SLLV, F_SLL, F_SRLV, F_SRL: c = C_ALU;
          F_MUL:                        c = C_MUL;
          F_JR:                         c = C_JR;
          default:                      c = C_ILL;
        endcase
      end
      OP_J:    c = C_J;
      OP_JAL:  c = C_JAL;
      OP_BEQ:  c = C_BEQ;
      OP_BNEZ: c = C_BNEZ;
      OP_BGEZ: c = C_BGEZ;
      OP_BGT:  c = C_BGT;
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      OP_ADDI: c = C_ADDI;
      OP_ORI:  c = C_ORI;
      OP_LUI:  c = C_LUI;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] op_q, fn_q;
  iclass_t    cls_dec, cls_lat;
  logic       mul_done;
  logic       branch_taken;

  // Combinational strobes before reset gating
  logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c;
  logic [1:0] pc_src_c;
  logic       reg_write_c;
  logic [1:0] reg_dst_c, wb_sel_c;
  logic       alu_a_sel_c;
  logic [1:0] alu_b_sel_c;
  logic       zext_c;
  logic [1:0] alu_op_c;

  // DECODE sees the freshly loaded IR; later states use the copy latched in DECODE
  assign cls_dec = classify(opcode_i, funct_i);
  assign cls_lat = classify(op_q, fn_q);

  // State register plus opcode/funct capture while in DECODE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode_i;
        fn_q <= funct_i;
      end
    end
  end

`ifdef MUL_STALL_EN
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  logic [3:0] mul_cnt_q;

  // Remaining extra EXEC cycles for mul; loaded on the DECODE->EXEC transition
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_cnt_q <= '0;
    end else if (state_q == S_DECODE) begin
      mul_cnt_q <= MUL_LOAD;
    end else if (state_q == S_EXEC && mul_cnt_q != 4'd0) begin
      mul_cnt_q <= mul_cnt_q - 4'd1;
    end
  end

  assign mul_done = (mul_cnt_q == 4'd0);
`else
  // MUL_CYCLES has no effect when mul completes in a single EXEC cycle
  logic [31:0] mul_cycles_unused;
  assign mul_cycles_unused = MUL_CYCLES;
  assign mul_done          = 1'b1;
`endif

  // Branch condition evaluated on the rs-rt subtraction flags during EXEC
  always_comb begin
    branch_taken = 1'b0;
    case (cls_lat)
      C_BEQ:   branch_taken = zero_i;
      C_BNEZ:  branch_taken = !zero_i;
      C_BGEZ:  branch_taken = !neg_i;
      C_BGT:   branch_taken = !zero_i && !neg_i;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state and datapath control, one state per cycle
  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    iord_c      = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 2'd0;
    reg_write_c = 1'b0;
    reg_dst_c   = 2'd0;
    wb_sel_c    = 2'd0;
    alu_a_sel_c = 1'b0;
    alu_b_sel_c = 2'd0;
    zext_c      = 1'b0;
    alu_op_c    = 2'd0;

    case (state_q)
      S_FETCH: begin
        // Instruction read from PC; the ALU computes PC+4 in parallel
        mem_req_c   = 1'b1;
        iord_c      = 1'b0;
        alu_a_sel_c = 1'b0;
        alu_b_sel_c = 2'd1;
        alu_op_c    = 2'd0;
        if (mem_ack_i) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          pc_src_c   = 2'd0;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculative branch target PC + (simm << 2) into ALUOut
        alu_a_sel_c = 1'b0;
        alu_b_sel_c = 2'd3;
        alu_op_c    = 2'd0;
        state_d     = (cls_dec == C_ILL) ? S_ERR : S_EXEC;
      end

      S_EXEC: begin
        case (cls_lat)
          C_ALU: begin
            alu_a_sel_c = 1'b1;
            alu_b_sel_c = 2'd0;
            alu_op_c    = 2'd2;
            state_d     = S_WB;
          end
          C_MUL: begin
            alu_a_sel_c = 1'b1;
            alu_b_sel_c = 2'd0;
            alu_op_c    = 2'd2;
            state_d     = mul_done ? S_WB : S_EXEC;
          end
          C_JR: begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'd3;
            state_d    = S_FETCH;
          end
          C_J: begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'd2;
            state_d    = S_FETCH;
          end
          C_JAL: begin
            // PC already holds the return address (PC+4) from FETCH
            pc_write_c  = 1'b1;
            pc_src_c    = 2'd2;
            reg_write_c = 1'b1;
            reg_dst_c   = 2'd2;
            wb_sel_c    = 2'd2;
            state_d     = S_FETCH;
          end
          C_BEQ, C_BNEZ, C_BGEZ, C_BGT: begin
            alu_a_sel_c = 1'b1;
            alu_b_sel_c = 2'd0;
            alu_op_c    = 2'd1;
            pc_write_c  = branch_taken;
            pc_src_c    = branch_taken ? 2'd1 : 2'd0;
            state_d     = S_FETCH;
          end
          C_LW, C_SW, C_ADDI: begin
            alu_a_sel_c = 1'b1;
            alu_b_sel_c = 2'd2;
            alu_op_c    = 2'd0;
            state_d     = (cls_lat == C_ADDI) ? S_WB : S_MEM;
          end
          C_ORI: begin
            alu_a_sel_c = 1'b1;
            alu_b_sel_c = 2'd2;
            zext_c      = 1'b1;
            alu_op_c    = 2'd3;
            state_d     = S_WB;
          end
          C_LUI: begin
            state_d = S_WB;
          end
          default: begin
            state_d = S_ERR;
          end
        endcase
      end

      S_MEM: begin
        // Address and direction held steady until the ack cycle
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_we_c  = (cls_lat == C_SW);
        if (mem_ack_i) begin
          state_d = (cls_lat == C_LW) ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = (cls_lat == C_ALU || cls_lat == C_MUL) ? 2'd1 : 2'd0;
        if (cls_lat == C_LW) begin
          wb_sel_c = 2'd1;
        end else if (cls_lat == C_LUI) begin
          wb_sel_c = 2'd3;
        end else begin
          wb_sel_c = 2'd0;
        end
        state_d = S_FETCH;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset masks every output in the reset cycle itself, dropping any pending request at once
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    iord_o      = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 2'd0;
    reg_write_o = 1'b0;
    reg_dst_o   = 2'd0;
    wb_sel_o    = 2'd0;
    alu_a_sel_o = 1'b0;
    alu_b_sel_o = 2'd0;
    zext_o      = 1'b0;
    alu_op_o    = 2'd0;
    state_o     = 3'd0;
    err_o       = 1'b0;
    if (!rst_i) begin
      mem_req_o   = mem_req_c;
      mem_we_o    = mem_we_c;
      iord_o      = iord_c;
      ir_write_o  = ir_write_c;
      pc_write_o  = pc_write_c;
      pc_src_o    = pc_src_c;
      reg_write_o = reg_write_c;
      reg_dst_o   = reg_dst_c;
      wb_sel_o    = wb_sel_c;
      alu_a_sel_o = alu_a_sel_c;
      alu_b_sel_o = alu_b_sel_c;
      zext_o      = zext_c;
      alu_op_o    = alu_op_c;
      state_o     = state_q;
      err_o       = (state_q == S_ERR);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int MUL_C = 4;
`ifdef MUL_STALL_EN
  localparam int MUL_EXEC = MUL_C;
`else
  localparam int MUL_EXEC = 1;
`endif

  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_X = 3'd5;

  // ALU control vector {a_sel, b_sel, alu_op, zext}
  localparam logic [5:0] ALU_PC4  = 6'b0_01_00_0;
  localparam logic [5:0] ALU_BTA  = 6'b0_11_00_0;
  localparam logic [5:0] ALU_R    = 6'b1_00_10_0;
  localparam logic [5:0] ALU_BR   = 6'b1_00_01_0;
  localparam logic [5:0] ALU_IMM  = 6'b1_10_00_0;
  localparam logic [5:0] ALU_ORI  = 6'b1_10_11_1;

  localparam int K_R = 0, K_MUL = 1, K_JR = 2, K_J = 3, K_JAL = 4, K_BEQ = 5, K_BNEZ = 6,
                 K_BGEZ = 7, K_BGT = 8, K_LW = 9, K_SW = 10, K_ADDI = 11, K_ORI = 12,
                 K_LUI = 13, K_ILL = 14;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] opcode_i = 6'd0;
  logic [5:0] funct_i = 6'd0;
  logic       zero_i = 1'b0;
  logic       neg_i = 1'b0;
  logic       mem_ack_i = 1'b0;
  logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
  logic [1:0] pc_src_o;
  logic       reg_write_o;
  logic [1:0] reg_dst_o, wb_sel_o;
  logic       alu_a_sel_o;
  logic [1:0] alu_b_sel_o;
  logic       zext_o;
  logic [1:0] alu_op_o;
  logic [2:0] state_o;
  logic       err_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [5:0] op;
    logic [5:0] fn;
    logic       rst;
    logic       ack;
    logic       z;
    logic       n;
    logic [15:0] ctl;
    logic       care;
    logic [5:0] alu;
  } exp_t;

  exp_t sbq[$];

  multicycle_ctrl #(.MUL_CYCLES(MUL_C)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .neg_i(neg_i), .mem_ack_i(mem_ack_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .wb_sel_o(wb_sel_o),
    .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o), .zext_o(zext_o),
    .alu_op_o(alu_op_o), .state_o(state_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Fields that are don't-care while their strobe is low are forced to zero
  function automatic logic [15:0] pack_ctl(input logic [2:0] st, input logic req, input logic we,
                                           input logic io, input logic irw, input logic pcw,
                                           input logic [1:0] pcs, input logic rw, input logic [1:0] rd,
                                           input logic [1:0] wbs, input logic err);
    return {st, req, req & we, req & io, irw, pcw, pcw ? pcs : 2'd0,
            rw, rw ? rd : 2'd0, rw ? wbs : 2'd0, err};
  endfunction

  function automatic int tb_class(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h04, 6'h00, 6'h06, 6'h02: return K_R;
               6'h18: return K_MUL;
               6'h08: return K_JR;
               default: return K_ILL;
             endcase
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h04: return K_BEQ;
      6'h05: return K_BNEZ;
      6'h01: return K_BGEZ;
      6'h07: return K_BGT;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h08: return K_ADDI;
      6'h0d: return K_ORI;
      6'h0f: return K_LUI;
      default: return K_ILL;
    endcase
  endfunction

  task automatic push(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic rst, input logic ack, input logic z, input logic n,
                      input logic [15:0] ctl, input logic care, input logic [5:0] alu);
    exp_t r;
    r.tag = tag; r.op = op; r.fn = fn; r.rst = rst; r.ack = ack; r.z = z; r.n = n;
    r.ctl = ctl; r.care = care; r.alu = alu;
    sbq.push_back(r);
  endtask

  task automatic push_rst(input string tag);
    push(tag, 6'd0, 6'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0,
         pack_ctl(ST_F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0), 1'b0, 6'd0);
  endtask

  task automatic push_err(input string tag, input logic [5:0] op, input logic [5:0] fn, input int cycles);
    for (int i = 0; i < cycles; i++)
      push(tag, op, fn, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0,
           pack_ctl(ST_X, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1), 1'b0, 6'd0);
  endtask

  // Expected per-cycle trace of one instruction; ack is held high outside FETCH/MEM waits
  task automatic gen_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input logic z, input logic n, input bit abort);
    int   cls;
    logic taken;
    logic [15:0] none_e;
    cls    = tb_class(op, fn);
    none_e = pack_ctl(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < fw; i++)
      push({nm, "/fetch_wait"}, op, fn, 1'b0, 1'b0, z, n,
           pack_ctl(ST_F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0), 1'b0, 6'd0);
    push({nm, "/fetch"}, op, fn, 1'b0, 1'b1, z, n,
         pack_ctl(ST_F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0), 1'b1, ALU_PC4);
    push({nm, "/decode"}, op, fn, 1'b0, 1'b1, z, n,
         pack_ctl(ST_D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0), 1'b1, ALU_BTA);
    case (cls)
      K_R, K_MUL: begin
        for (int i = 0; i < ((cls == K_MUL) ? MUL_EXEC : 1); i++)
          push({nm, "/exec"}, op, fn, 1'b0, 1'b1, z, n, none_e, 1'b1, ALU_R);
        push({nm, "/wb"}, op, fn, 1'b0, 1'b1, z, n,
             pack_ctl(ST_W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0), 1'b0, 6'd0);
      end
      K_JR, K_J:
        push({nm, "/exec"}, op, fn, 1'b0, 1'b1, z, n,
             pack_ctl(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (cls == K_JR) ? 2'd3 : 2'd2,
                      1'b0, 2'd0, 2'd0, 1'b0), 1'b0, 6'd0);
      K_JAL:
        push({nm, "/exec"}, op, fn, 1'b0, 1'b1, z, n,
             pack_ctl(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b0), 1'b0, 6'd0);
      K_BEQ, K_BNEZ, K_BGEZ, K_BGT: begin
        taken = (cls == K_BEQ)  ? z :
                (cls == K_BNEZ) ? !z :
                (cls == K_BGEZ) ? !n : (!z && !n);
        push({nm, "/exec"}, op, fn, 1'b0, 1'b1, z, n,
             pack_ctl(ST_E, 1'b0, 1'b0, 1'b0, 1'b0, taken, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0), 1'b1, ALU_BR);
      end
      K_LW, K_SW: begin
        push({nm, "/exec"}, op, fn, 1'b0, 1'b1, z, n, none_e, 1'b1, ALU_IMM);
        for (int i = 0; i < mw; i++)
          push({nm, "/mem_wait"}, op, fn, 1'b0, 1'b0, z, n,
               pack_ctl(ST_M, 1'b1, cls == K_SW, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0), 1'b0, 6'd0);
        if (abort) begin
          push_rst({nm, "/rst_in_mem"});
          push_rst({nm, "/rst_after_mem"});
        end else begin
          push({nm, "/mem"}, op, fn, 1'b0, 1'b1, z, n,
               pack_ctl(ST_M, 1'b1, cls == K_SW, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0), 1'b0, 6'd0);
          if (cls == K_LW)
            push({nm, "/wb"}, op, fn, 1'b0, 1'b1, z, n,
                 pack_ctl(ST_W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0), 1'b0, 6'd0);
        end
      end
      K_ADDI, K_ORI, K_LUI: begin
        push({nm, "/exec"}, op, fn, 1'b0, 1'b1, z, n, none_e, cls != K_LUI,
             (cls == K_ORI) ? ALU_ORI : ALU_IMM);
        push({nm, "/wb"}, op, fn, 1'b0, 1'b1, z, n,
             pack_ctl(ST_W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0,
                      (cls == K_LUI) ? 2'd3 : 2'd0, 1'b0), 1'b0, 6'd0);
      end
      default: ;
    endcase
  endtask

  // Drive one cycle of stimulus from the scoreboard head and compare at the falling edge
  task automatic step();
    exp_t r;
    r = sbq.pop_front();
    rst_i     = r.rst;
    opcode_i  = r.op;
    funct_i   = r.fn;
    mem_ack_i = r.ack;
    zero_i    = r.z;
    neg_i     = r.n;
    @(negedge clk);
    check(r.tag, 32'(pack_ctl(state_o, mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
                              reg_write_o, reg_dst_o, wb_sel_o, err_o)), 32'(r.ctl));
    if (r.care)
      check({r.tag, "/alu"}, 32'({alu_a_sel_o, alu_b_sel_o, alu_op_o, zext_o}), 32'(r.alu));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (sbq.size() > 0) step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) push_rst("reset");
    gen_instr("addi",    6'h08, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("beq_t",   6'h04, 6'h00, 0, 0, 1'b1, 1'b0, 1'b0);
    gen_instr("beq_nt",  6'h04, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("lw_wait", 6'h23, 6'h00, 2, 3, 1'b0, 1'b0, 1'b0);
    gen_instr("jal",     6'h03, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    drain();
    gen_instr("add",     6'h00, 6'h20, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("sub",     6'h00, 6'h22, 1, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("slt",     6'h00, 6'h2a, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("srl",     6'h00, 6'h02, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("mul",     6'h00, 6'h18, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("jr",      6'h00, 6'h08, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("j",       6'h02, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("bnez_t",  6'h05, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("bnez_nt", 6'h05, 6'h00, 0, 0, 1'b1, 1'b0, 1'b0);
    gen_instr("bgez_t",  6'h01, 6'h00, 0, 0, 1'b1, 1'b0, 1'b0);
    gen_instr("bgez_nt", 6'h01, 6'h00, 0, 0, 1'b0, 1'b1, 1'b0);
    gen_instr("bgt_t",   6'h07, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("bgt_neg", 6'h07, 6'h00, 0, 0, 1'b0, 1'b1, 1'b0);
    gen_instr("bgt_eq",  6'h07, 6'h00, 0, 0, 1'b1, 1'b0, 1'b0);
    gen_instr("sw",      6'h2b, 6'h00, 0, 1, 1'b0, 1'b0, 1'b0);
    gen_instr("ori",     6'h0d, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("lui",     6'h0f, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    drain();
    gen_instr("bad_fn",  6'h00, 6'h3f, 0, 0, 1'b0, 1'b0, 1'b0);
    push_err("bad_fn/err", 6'h00, 6'h3f, 3);
    push_rst("bad_fn/rst");
    gen_instr("bad_op",  6'h3f, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    push_err("bad_op/err", 6'h3f, 6'h00, 20);
    push_rst("bad_op/rst");
    gen_instr("addi2",   6'h08, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    gen_instr("sw_rst",  6'h2b, 6'h00, 0, 1, 1'b0, 1'b0, 1'b1);
    gen_instr("lw_post", 6'h23, 6'h00, 1, 0, 1'b0, 1'b0, 1'b0);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
